// File: rtl/approx_mult_err_engine.sv
// approx_mult_err_engine
// On-chip error-characterisation engine for an external W x W approximate
// multiplier. Sweeps operand pairs (exhaustive or LFSR-random) at one pair per
// clock. Each returned product is compared against an internally computed
// exact product that is delayed to line up with the multiplier's LAT-cycle
// latency. The engine accumulates the sample count, the error count, the sum
// of error distances and the maximum error distance.
//
// Ports:
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   start             launch a run (sampled only when idle or done)
//   mode              0 = exhaustive sweep, 1 = LFSR random (latched at start)
//   num_samples       pair count for random mode (latched at start)
//   seed              LFSR seed, 0 is replaced by 1 (latched at start)
//   op_a, op_b        operands driven to the multiplier
//   approx_y          multiplier result, LAT cycles after op_a/op_b
//   busy, done        run in progress / results valid
//   total_count       pairs compared
//   err_count         pairs with a non-zero error distance
//   max_ed, sum_ed    maximum and sum of |approx_y - exact|
module approx_mult_err_engine #(
  parameter int unsigned W     = 16,
  parameter int unsigned LAT   = 0,
  parameter int unsigned CNT_W = 2*W+1,
  parameter int unsigned SUM_W = 4*W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] num_samples,
  input  logic [2*W-1:0]   seed,
  output logic [W-1:0]     op_a,
  output logic [W-1:0]     op_b,
  input  logic [2*W-1:0]   approx_y,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] total_count,
  output logic [CNT_W-1:0] err_count,
  output logic [2*W-1:0]   max_ed,
  output logic [SUM_W-1:0] sum_ed
);

  localparam int unsigned WP      = 2*W;
  localparam int unsigned SUM_W1  = SUM_W + 1;
  localparam int unsigned DRAIN_W = $clog2(LAT + 2);

  // Maximal-length Fibonacci tap masks; tap t selects register bit t-1.
  function automatic logic [WP-1:0] lfsr_taps();
    int unsigned   t [4];
    logic [WP-1:0] m;
    case (WP)
      2:       t = '{2, 1, 0, 0};
      4:       t = '{4, 3, 0, 0};
      6:       t = '{6, 5, 0, 0};
      8:       t = '{8, 6, 5, 4};
      10:      t = '{10, 7, 0, 0};
      12:      t = '{12, 6, 4, 1};
      14:      t = '{14, 5, 3, 1};
      16:      t = '{16, 15, 13, 4};
      18:      t = '{18, 11, 0, 0};
      20:      t = '{20, 17, 0, 0};
      22:      t = '{22, 21, 0, 0};
      24:      t = '{24, 23, 22, 17};
      26:      t = '{26, 6, 2, 1};
      28:      t = '{28, 25, 0, 0};
      30:      t = '{30, 6, 4, 1};
      32:      t = '{32, 22, 2, 1};
      36:      t = '{36, 25, 0, 0};
      40:      t = '{40, 38, 21, 19};
      48:      t = '{48, 47, 21, 20};
      64:      t = '{64, 63, 61, 60};
      default: t = '{WP, WP - 1, 0, 0};
    endcase
    m = '0;
    for (int i = 0; i < 4; i++) begin
      if (t[i] != 0) m = m | (WP'(1) << (t[i] - 1));
    end
    return m;
  endfunction

  localparam logic [WP-1:0] TAPS = lfsr_taps();

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state;
  logic [WP-1:0]       pair;        // {op_a, op_b}; doubles as the LFSR state
  logic                mode_q;
  logic [CNT_W-1:0]    remaining;   // random pairs left after the current one
  logic [DRAIN_W-1:0]  drain_cnt;

  logic [WP-1:0]       exact_c;
  logic [WP-1:0]       next_pair_c;
  logic                last_pair_c;
  logic [WP-1:0]       seed_nz_c;
  logic                aligned_valid_c;
  logic [WP-1:0]       aligned_exact_c;
  logic [WP:0]         diff_c;
  logic [WP-1:0]       ed_c;
  logic [SUM_W1-1:0]   sum_add_c;

  assign op_a = pair[WP-1:W];
  assign op_b = pair[W-1:0];

  // Exact reference product for the pair currently on the operand bus.
  assign exact_c = WP'(op_a) * WP'(op_b);

  // Exhaustive: b is the low half, so a plain increment walks b fastest.
  assign next_pair_c = mode_q ? {pair[WP-2:0], ^(pair & TAPS)} : pair + WP'(1);
  assign last_pair_c = mode_q ? (remaining == '0) : (&pair);
  assign seed_nz_c   = (seed == '0) ? WP'(1) : seed;

  // Delay line aligning the exact product with approx_y.
  if (LAT == 0) begin : g_comb
    assign aligned_valid_c = (state == RUN);
    assign aligned_exact_c = exact_c;
  end else begin : g_dly
    logic [WP-1:0]  dly_exact [LAT];
    logic [LAT-1:0] dly_valid;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        dly_valid <= '0;
        for (int unsigned i = 0; i < LAT; i++) dly_exact[i] <= '0;
      end else begin
        dly_valid    <= (dly_valid << 1) | LAT'(state == RUN);
        dly_exact[0] <= exact_c;
        for (int unsigned i = 1; i < LAT; i++) dly_exact[i] <= dly_exact[i-1];
      end
    end

    assign aligned_valid_c = dly_valid[LAT-1];
    assign aligned_exact_c = dly_exact[LAT-1];
  end

  // Error distance from a one-bit-wider signed difference.
  assign diff_c    = {1'b0, approx_y} - {1'b0, aligned_exact_c};
  assign ed_c      = diff_c[WP] ? WP'(-diff_c) : diff_c[WP-1:0];
  assign sum_add_c = {1'b0, sum_ed} + SUM_W1'(ed_c);

  // Control FSM, operand generation and statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      pair        <= '0;
      mode_q      <= 1'b0;
      remaining   <= '0;
      drain_cnt   <= '0;
      total_count <= '0;
      err_count   <= '0;
      max_ed      <= '0;
      sum_ed      <= '0;
    end else begin
      // Saturating statistics update for each aligned valid comparison.
      if (aligned_valid_c) begin
        if (!(&total_count)) total_count <= total_count + CNT_W'(1);
        if ((ed_c != '0) && !(&err_count)) err_count <= err_count + CNT_W'(1);
        sum_ed <= sum_add_c[SUM_W] ? '1 : sum_add_c[SUM_W-1:0];
        if (ed_c > max_ed) max_ed <= ed_c;
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            done        <= 1'b0;
            mode_q      <= mode;
            total_count <= '0;
            err_count   <= '0;
            max_ed      <= '0;
            sum_ed      <= '0;
            if (mode && (num_samples == '0)) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state     <= RUN;
              busy      <= 1'b1;
              pair      <= mode ? seed_nz_c : '0;
              remaining <= num_samples - CNT_W'(1);
            end
          end
        end
        RUN: begin
          if (last_pair_c) begin
            if (LAT == 0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_W'(LAT - 1);
            end
          end else begin
            pair      <= next_pair_c;
            remaining <= remaining - CNT_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_mult_err_engine.sv
// Directed testbench for approx_mult_err_engine: four instances with exact,
// bit0-truncated and pipelined multiplier stubs at W=4 and W=8.
module tb_approx_mult_err_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // Shared run inputs for the W=4 instances
  logic       md;
  logic [8:0] ns;
  logic [7:0] sd;

  // u0: W=4, LAT=0, exact stub
  logic st0, bz0, dn0; logic [3:0] a0, b0; logic [7:0] y0, me0;
  logic [8:0] tc0, ec0; logic [15:0] se0;
  // u1: W=4, LAT=0, bit0 forced to 0
  logic st1, bz1, dn1; logic [3:0] a1, b1; logic [7:0] y1, me1;
  logic [8:0] tc1, ec1; logic [15:0] se1;
  // u2: W=4, LAT=3, exact stub pipelined
  logic st2, bz2, dn2; logic [3:0] a2, b2; logic [7:0] y2, me2;
  logic [8:0] tc2, ec2; logic [15:0] se2;
  logic [7:0] p2 [3];
  // u3: W=8, LAT=0, bit0 forced to 0
  logic st3, md3, bz3, dn3; logic [7:0] a3, b3; logic [15:0] sd3, y3, me3;
  logic [16:0] ns3, tc3, ec3; logic [31:0] se3;

  assign y0 = 8'(a0) * 8'(b0);
  assign y1 = (8'(a1) * 8'(b1)) & 8'hFE;
  assign y3 = (16'(a3) * 16'(b3)) & 16'hFFFE;
  always_ff @(posedge clk) begin
    p2[0] <= 8'(a2) * 8'(b2);
    p2[1] <= p2[0];
    p2[2] <= p2[1];
  end
  assign y2 = p2[2];

  approx_mult_err_engine #(.W(4), .LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st0), .mode(md), .num_samples(ns), .seed(sd),
    .op_a(a0), .op_b(b0), .approx_y(y0), .busy(bz0), .done(dn0),
    .total_count(tc0), .err_count(ec0), .max_ed(me0), .sum_ed(se0));
  approx_mult_err_engine #(.W(4), .LAT(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .mode(md), .num_samples(ns), .seed(sd),
    .op_a(a1), .op_b(b1), .approx_y(y1), .busy(bz1), .done(dn1),
    .total_count(tc1), .err_count(ec1), .max_ed(me1), .sum_ed(se1));
  approx_mult_err_engine #(.W(4), .LAT(3)) u2 (
    .clk(clk), .rst_n(rst_n), .start(st2), .mode(md), .num_samples(ns), .seed(sd),
    .op_a(a2), .op_b(b2), .approx_y(y2), .busy(bz2), .done(dn2),
    .total_count(tc2), .err_count(ec2), .max_ed(me2), .sum_ed(se2));
  approx_mult_err_engine #(.W(8), .LAT(0)) u3 (
    .clk(clk), .rst_n(rst_n), .start(st3), .mode(md3), .num_samples(ns3), .seed(sd3),
    .op_a(a3), .op_b(b3), .approx_y(y3), .busy(bz3), .done(dn3),
    .total_count(tc3), .err_count(ec3), .max_ed(me3), .sum_ed(se3));

  function automatic logic get_busy(input int sel);
    case (sel)
      0: return bz0;
      1: return bz1;
      2: return bz2;
      default: return bz3;
    endcase
  endfunction

  function automatic logic get_done(input int sel);
    case (sel)
      0: return dn0;
      1: return dn1;
      2: return dn2;
      default: return dn3;
    endcase
  endfunction

  // Pulse start for one instance; returns #1 after the accepting edge E0.
  task automatic pulse_start(input int sel);
    @(negedge clk);
    case (sel)
      0: st0 = 1'b1;
      1: st1 = 1'b1;
      2: st2 = 1'b1;
      default: st3 = 1'b1;
    endcase
    @(posedge clk);
    #1;
    st0 = 1'b0; st1 = 1'b0; st2 = 1'b0; st3 = 1'b0;
  endtask

  // Edges until done is seen (bounded) and busy samples from E0 onwards.
  task automatic wait_done(input int sel, input int limit, output int cycles, output int bcyc);
    cycles = 0;
    bcyc   = get_busy(sel) ? 1 : 0;
    while (cycles < limit) begin
      @(posedge clk);
      #1;
      cycles++;
      if (get_busy(sel)) bcyc++;
      if (get_done(sel)) break;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    st0 = 0; st1 = 0; st2 = 0; st3 = 0;
    md = 0; ns = '0; sd = '0; md3 = 0; ns3 = '0; sd3 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bz0, dn0, a0, b0, tc0, ec0, me0, se0} !== '0) begin
      errors++; $display("FAIL reset_u0: got %h expected 0", {bz0, dn0, a0, b0, tc0, ec0, me0, se0});
    end
    checks++;
    if ({bz2, dn2, a2, b2, tc2, ec2, me2, se2} !== '0) begin
      errors++; $display("FAIL reset_u2: got %h expected 0", {bz2, dn2, a2, b2, tc2, ec2, me2, se2});
    end
    checks++;
    if ({bz3, dn3, a3, b3, tc3, ec3, me3, se3} !== '0) begin
      errors++; $display("FAIL reset_u3: got %h expected 0", {bz3, dn3, a3, b3, tc3, ec3, me3, se3});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_exhaustive_exact;
    int cyc, bc;
    md = 0;
    pulse_start(0);
    checks++;
    if ({bz0, a0, b0} !== 9'h100) begin
      errors++; $display("FAIL exact_first_pair: got busy/a/b %h expected 100", {bz0, a0, b0});
    end
    wait_done(0, 400, cyc, bc);
    checks++;
    if (cyc !== 256) begin
      errors++; $display("FAIL exact_done_edge: got %0d expected 256", cyc);
    end
    checks++;
    if ({tc0, ec0, me0, se0} !== {9'd256, 9'd0, 8'd0, 16'd0}) begin
      errors++; $display("FAIL exact_stats: got tc=%0d ec=%0d me=%0d se=%0d expected 256/0/0/0", tc0, ec0, me0, se0);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({bz0, dn0, a0, b0, tc0} !== {1'b0, 1'b1, 4'hF, 4'hF, 9'd256}) begin
      errors++; $display("FAIL exact_done_hold: got busy=%0b done=%0b a=%0d b=%0d tc=%0d expected 0/1/15/15/256", bz0, dn0, a0, b0, tc0);
    end
  endtask

  task automatic test_exhaustive_approx;
    int cyc, bc;
    md = 0;
    pulse_start(1);
    @(posedge clk);
    #1;
    checks++;
    if ({a1, b1} !== 8'h01) begin
      errors++; $display("FAIL approx_second_pair: got a=%0d b=%0d expected 0/1", a1, b1);
    end
    wait_done(1, 400, cyc, bc);
    checks++;
    if ((cyc + 1) !== 256) begin
      errors++; $display("FAIL approx_done_edge: got %0d expected 256", cyc + 1);
    end
    checks++;
    if ({tc1, ec1, me1, se1} !== {9'd256, 9'd64, 8'd1, 16'd64}) begin
      errors++; $display("FAIL approx_stats: got tc=%0d ec=%0d me=%0d se=%0d expected 256/64/1/64", tc1, ec1, me1, se1);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, bc;
    pulse_start(1);
    checks++;
    if ({bz1, dn1, tc1, ec1, me1, se1} !== {1'b1, 1'b0, 42'd0}) begin
      errors++; $display("FAIL restart_clear: got busy=%0b done=%0b tc=%0d ec=%0d expected 1/0/0/0", bz1, dn1, tc1, ec1);
    end
    wait_done(1, 400, cyc, bc);
    checks++;
    if ({cyc[8:0], tc1, ec1, me1, se1} !== {9'd256, 9'd256, 9'd64, 8'd1, 16'd64}) begin
      errors++; $display("FAIL restart_stats: got cyc=%0d tc=%0d ec=%0d me=%0d se=%0d expected 256/256/64/1/64", cyc, tc1, ec1, me1, se1);
    end
  endtask

  task automatic test_pipelined;
    int cyc, bc;
    md = 0;
    pulse_start(2);
    wait_done(2, 400, cyc, bc);
    checks++;
    if (cyc !== 259) begin
      errors++; $display("FAIL pipe_done_edge: got %0d expected 259", cyc);
    end
    checks++;
    if (bc !== 259) begin
      errors++; $display("FAIL pipe_busy_cycles: got %0d expected 259", bc);
    end
    checks++;
    if ({tc2, ec2, me2, se2} !== {9'd256, 9'd0, 8'd0, 16'd0}) begin
      errors++; $display("FAIL pipe_stats: got tc=%0d ec=%0d me=%0d se=%0d expected 256/0/0/0", tc2, ec2, me2, se2);
    end
  endtask

  task automatic test_random_zero;
    md3 = 1; ns3 = '0; sd3 = 16'h1234;
    pulse_start(3);
    checks++;
    if ({bz3, dn3, tc3, ec3, me3, se3} !== {1'b0, 1'b1, 82'd0}) begin
      errors++; $display("FAIL rand_zero: got busy=%0b done=%0b tc=%0d ec=%0d me=%0d se=%0d expected 0/1/0/0/0/0", bz3, dn3, tc3, ec3, me3, se3);
    end
  endtask

  logic [15:0] seq1 [1000];
  logic [15:0] seq2 [1000];

  task automatic test_random_seed;
    int n1, n2, g1, g2, diffs;
    logic [16:0] tc_r, ec_r; logic [15:0] me_r; logic [31:0] se_r;
    md3 = 1; ns3 = 17'd1000; sd3 = 16'h0000;
    pulse_start(3);
    checks++;
    if ({a3, b3} !== 16'h0001) begin
      errors++; $display("FAIL rand_seed0_first: got %h expected 0001", {a3, b3});
    end
    n1 = 0; g1 = 0;
    while (!dn3 && g1 < 3000) begin
      if (bz3 && n1 < 1000) begin seq1[n1] = {a3, b3}; n1++; end
      @(posedge clk); #1; g1++;
    end
    tc_r = tc3; ec_r = ec3; me_r = me3; se_r = se3;
    checks++;
    if ({n1[10:0], g1[10:0], tc3} !== {11'd1000, 11'd1000, 17'd1000}) begin
      errors++; $display("FAIL rand_len: got pairs=%0d edges=%0d tc=%0d expected 1000/1000/1000", n1, g1, tc3);
    end
    checks++;
    if (me3 !== 16'd1 || ec3 !== se3[16:0] || ec3 == 17'd0) begin
      errors++; $display("FAIL rand_err_shape: got me=%0d ec=%0d se=%0d expected me=1 and ec=se>0", me3, ec3, se3);
    end
    sd3 = 16'h0001;
    pulse_start(3);
    n2 = 0; g2 = 0;
    while (!dn3 && g2 < 3000) begin
      if (bz3 && n2 < 1000) begin seq2[n2] = {a3, b3}; n2++; end
      @(posedge clk); #1; g2++;
    end
    diffs = 0;
    for (int i = 0; i < 1000; i++) if (seq1[i] !== seq2[i]) diffs++;
    checks++;
    if (diffs !== 0 || n2 !== 1000) begin
      errors++; $display("FAIL rand_seq_equal: got %0d differing pairs of %0d expected 0 of 1000", diffs, n2);
    end
    checks++;
    if ({tc3, ec3, me3, se3} !== {tc_r, ec_r, me_r, se_r}) begin
      errors++; $display("FAIL rand_stats_equal: got tc=%0d ec=%0d se=%0d expected %0d/%0d/%0d", tc3, ec3, se3, tc_r, ec_r, se_r);
    end
  endtask

  task automatic test_start_ignored;
    int cyc, bc;
    md = 0;
    pulse_start(0);
    repeat (50) @(posedge clk);
    md = 1; ns = 9'd5; sd = 8'h55;
    pulse_start(0);
    md = 0;
    wait_done(0, 400, cyc, bc);
    checks++;
    if (cyc !== 205) begin
      errors++; $display("FAIL ignore_start_edge: got %0d expected 205", cyc);
    end
    checks++;
    if ({tc0, ec0, me0, se0, a0, b0} !== {9'd256, 9'd0, 8'd0, 16'd0, 4'hF, 4'hF}) begin
      errors++; $display("FAIL ignore_start_stats: got tc=%0d ec=%0d a=%0d b=%0d expected 256/0/15/15", tc0, ec0, a0, b0);
    end
  endtask

  task automatic test_reset_midrun;
    int cyc, bc;
    md = 0;
    pulse_start(1);
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if ({tc1, ec1, me1, se1} !== {9'd100, 9'd24, 8'd1, 16'd24}) begin
      errors++; $display("FAIL midrun_stats: got tc=%0d ec=%0d me=%0d se=%0d expected 100/24/1/24", tc1, ec1, me1, se1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({bz1, dn1, a1, b1, tc1, ec1, me1, se1} !== '0) begin
      errors++; $display("FAIL midrun_reset: got %h expected 0", {bz1, dn1, a1, b1, tc1, ec1, me1, se1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start(1);
    wait_done(1, 400, cyc, bc);
    checks++;
    if ({cyc[8:0], tc1, ec1, me1, se1} !== {9'd256, 9'd256, 9'd64, 8'd1, 16'd64}) begin
      errors++; $display("FAIL post_reset_run: got cyc=%0d tc=%0d ec=%0d me=%0d se=%0d expected 256/256/64/1/64", cyc, tc1, ec1, me1, se1);
    end
  endtask

  initial begin
    test_reset;
    test_exhaustive_exact;
    test_exhaustive_approx;
    test_back_to_back;
    test_pipelined;
    test_random_zero;
    test_random_seed;
    test_start_ignored;
    test_reset_midrun;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
